// File: rtl/add3_share_pkg.sv
// Shared constants, slot-state encoding and round-robin pick helper for add3_share_arbiter.
// Optional feature macro: ADD3_SHARE_CARRY_EN (carry-out of the shared adder).
package add3_share_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_NREQ  = 3;
    localparam int MAX_NREQ      = 16;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Next grant: first set bit of valid after 'last', wrapping at nreq rather
    // than at a power of two so non-power-of-two requester counts stay fair.
    function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                           input logic [3:0]          last,
                                           input int                  nreq);
        int         cand;
        logic       found;
        logic [3:0] pick;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            cand = int'(last) + k;
            if (cand >= nreq) begin
                cand = cand - nreq;
            end
            if ((k <= nreq) && !found && valid[cand[3:0]]) begin
                pick  = cand[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/add3_share_arbiter_add3_core.sv
// Purely combinational 3-operand modular adder; the shared resource behind the arbiter.
// With ADD3_SHARE_CARRY_EN defined it also returns the two bits above the WIDTH-bit sum.
module add3_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
`ifdef ADD3_SHARE_CARRY_EN
    output logic [1:0]       carry,
`endif
    output logic [WIDTH-1:0] sum
);

`ifdef ADD3_SHARE_CARRY_EN
    logic [WIDTH+1:0] full_sum;

    // Three WIDTH-bit operands need at most WIDTH+2 bits.
    assign full_sum = {2'b00, in1} + {2'b00, in2} + {2'b00, in3};
    assign sum      = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH+1:WIDTH];
`else
    assign sum = in1 + in2 + in3;
`endif

endmodule

// File: rtl/add3_share_arbiter.sv
// Round-robin arbiter sharing one 3-operand adder among NREQ requesters, single-entry response slot.
// Optional feature macro: ADD3_SHARE_CARRY_EN adds the registered rsp_carry output.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// Ready never waits on valid of the same channel beyond arbitration; valid, once
// raised by this block (rsp_valid), holds its payload stable until rsp_ready.
module add3_share_arbiter
    import add3_share_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*WIDTH-1:0] req_in2,
    input  logic [NREQ*WIDTH-1:0] req_in3,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id,
`ifdef ADD3_SHARE_CARRY_EN
    output logic [1:0]            rsp_carry,
`endif
    output logic [CNTW-1:0]       op_count,
    output slot_state_e           slot_state
);

    slot_state_e           state_q, state_d;
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        grant;
    logic [MAX_NREQ-1:0]   valid_wide;
    logic                  any_valid;
    logic                  slot_free;
    logic                  accept;
    logic [WIDTH-1:0]      sel_in1, sel_in2, sel_in3;
    logic [WIDTH-1:0]      core_sum;
`ifdef ADD3_SHARE_CARRY_EN
    logic [1:0]            core_carry;
`endif

    assign rsp_valid  = (state_q == SLOT_FULL);
    assign slot_state = state_q;
    assign slot_free  = ~rsp_valid | rsp_ready;
    assign any_valid  = |req_valid;

    always_comb begin
        valid_wide = '0;
        for (int r = 0; r < NREQ; r++) begin
            valid_wide[r] = req_valid[r];
        end
    end

    assign grant = IDW'(rr_pick(valid_wide, 4'(last_grant), NREQ));

    always_comb begin
        req_ready = '0;
        if (!rst && slot_free && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    assign sel_in1 = req_in1[grant*WIDTH +: WIDTH];
    assign sel_in2 = req_in2[grant*WIDTH +: WIDTH];
    assign sel_in3 = req_in3[grant*WIDTH +: WIDTH];

    add3_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in1   (sel_in1),
        .in2   (sel_in2),
        .in3   (sel_in3),
`ifdef ADD3_SHARE_CARRY_EN
        .carry (core_carry),
`endif
        .sum   (core_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A drain and a new accept in the same cycle keep the slot FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept) begin
                    state_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum    <= '0;
            rsp_id     <= '0;
            last_grant <= IDW'(NREQ - 1);
            op_count   <= '0;
        end else if (accept) begin
            rsp_sum    <= core_sum;
            rsp_id     <= grant;
            last_grant <= grant;
            if (op_count != {CNTW{1'b1}}) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

`ifdef ADD3_SHARE_CARRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_carry <= '0;
        end else if (accept) begin
            rsp_carry <= core_carry;
        end
    end
`endif

endmodule

// File: tb/tb_add3_share_arbiter.sv
// Directed self-checking bench for add3_share_arbiter (WIDTH=4, NREQ=3, CNTW=4).
// Build with ADD3_SHARE_CARRY_EN defined to also check rsp_carry.
module tb_add3_share_arbiter;
    import add3_share_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_in1, req_in2, req_in3;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic [CNTW-1:0]       op_count;
    slot_state_e           slot_state;
`ifdef ADD3_SHARE_CARRY_EN
    logic [1:0]            rsp_carry;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Expected results of the round-robin operand set, indexed by requester.
    logic [WIDTH-1:0] exp_sum_tab [NREQ];
    logic [1:0]       exp_cy_tab  [NREQ];

    always #5 clk = ~clk;

    add3_share_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_in3    (req_in3),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
`ifdef ADD3_SHARE_CARRY_EN
        .rsp_carry  (rsp_carry),
`endif
        .op_count   (op_count),
        .slot_state (slot_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cy(input string tag, input logic [1:0] exp);
`ifdef ADD3_SHARE_CARRY_EN
        chk(tag, 32'(rsp_carry), 32'(exp));
`else
        if (exp === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [WIDTH-1:0] s,
                           input logic [IDW-1:0] id, input logic [CNTW-1:0] cnt);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, ".sum"},   32'(rsp_sum),   32'(s));
        chk({tag, ".id"},    32'(rsp_id),    32'(id));
        chk({tag, ".count"}, 32'(op_count),  32'(cnt));
    endtask

    initial begin
        int exp_id;
        int exp_cnt;

        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_in3   = '0;
        step();
        step();

        // ready must stay low under reset even with requests pending
        req_valid = 3'b111;
        #1;
        chk("reset.ready", 32'(req_ready), 32'h0);
        chk_rsp("reset", 1'b0, 4'h0, 2'd0, 4'd0);
        chk("reset.state", 32'(slot_state), 32'(SLOT_EMPTY));
        chk_cy("reset.carry", 2'd0);

        req_valid = '0;
        rst       = 1'b0;
        step();

        // Basic: only requester 1, 3+5+9 = 17 -> sum 1, carry 1
        rsp_ready = 1'b1;
        req_valid = 3'b010;
        req_in1   = {4'h0, 4'h3, 4'h0};
        req_in2   = {4'h0, 4'h5, 4'h0};
        req_in3   = {4'h0, 4'h9, 4'h0};
        #1;
        chk("basic.ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk_rsp("basic", 1'b1, 4'h1, 2'd1, 4'd1);
        chk("basic.state", 32'(slot_state), 32'(SLOT_FULL));
        chk_cy("basic.carry", 2'd1);
        step();
        chk_rsp("drain", 1'b0, 4'h1, 2'd1, 4'd1);
        chk("idle.ready", 32'(req_ready), 32'h0);

        // Max operands on requester 0: 45 -> sum D, carry 2
        req_valid = 3'b001;
        req_in1   = {4'h0, 4'h0, 4'hF};
        req_in2   = {4'h0, 4'h0, 4'hF};
        req_in3   = {4'h0, 4'h0, 4'hF};
        #1;
        chk("max.ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk_rsp("max", 1'b1, 4'hD, 2'd0, 4'd2);
        chk_cy("max.carry", 2'd2);
        step();

        // Round robin after last grant 0: ids 1,2,0,1,2,0
        // r0: 1+2+3=6 ; r1: 7+8+9=24 -> 8 c1 ; r2: F+1+0=16 -> 0 c1
        exp_sum_tab[0] = 4'h6; exp_cy_tab[0] = 2'd0;
        exp_sum_tab[1] = 4'h8; exp_cy_tab[1] = 2'd1;
        exp_sum_tab[2] = 4'h0; exp_cy_tab[2] = 2'd1;
        req_in1   = {4'hF, 4'h7, 4'h1};
        req_in2   = {4'h1, 4'h8, 4'h2};
        req_in3   = {4'h0, 4'h9, 4'h3};
        req_valid = 3'b111;
        exp_cnt   = 2;
        for (int k = 0; k < 6; k++) begin
            exp_id = (k + 1) % 3;
            exp_cnt++;
            step();
            chk_rsp($sformatf("rr%0d", k), 1'b1, exp_sum_tab[exp_id], IDW'(exp_id), CNTW'(exp_cnt));
            chk_cy($sformatf("rr%0d.carry", k), exp_cy_tab[exp_id]);
        end

        // Backpressure: slot holds id 0, sum 6, count 8
        rsp_ready = 1'b0;
        #1;
        chk("bp.ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_rsp($sformatf("bp%0d", k), 1'b1, 4'h6, 2'd0, 4'd8);
            chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release.ready", 32'(req_ready), 32'h2);
        step();
        chk_rsp("release", 1'b1, 4'h8, 2'd1, 4'd9);

        // Reset while FULL drops the response and restores priority to requester 0
        rst = 1'b1;
        step();
        chk_rsp("midrst", 1'b0, 4'h0, 2'd0, 4'd0);
        chk_cy("midrst.carry", 2'd0);
        rst = 1'b0;
        #1;
        chk("postrst.ready", 32'(req_ready), 32'h1);
        step();
        chk_rsp("postrst", 1'b1, 4'h6, 2'd0, 4'd1);

        // Saturation: 20 accepts in total, counter sticks at 15
        for (int k = 2; k <= 20; k++) begin
            exp_id  = (k - 1) % 3;
            exp_cnt = (k > 15) ? 15 : k;
            step();
            chk($sformatf("sat%0d.id", k), 32'(rsp_id), 32'(exp_id));
            chk($sformatf("sat%0d.count", k), 32'(op_count), 32'(exp_cnt));
        end

        // Idle with slot drained: valid drops after one cycle and no priority movement
        req_valid = '0;
        step();
        chk("final.valid", 32'(rsp_valid), 32'h0);
        chk("final.count", 32'(op_count), 32'hF);
        req_valid = 3'b111;
        #1;
        // last accept was k=20 -> id 1, so next grant is requester 2
        chk("final.ready", 32'(req_ready), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
